adder_pipe_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined 64-bit adder (`adder_pipe_64bit`, fixed 4-cycle latency, no stall) among several requesters. Each requester submits an operand pair over a valid/ready handshake. The block issues one operation per cycle into the adder and tracks the requester ID alongside each in-flight operation. Results return through a credit-protected response FIFO with a valid/ready output, so downstream backpressure never overflows the non-stallable pipeline.

---
 rtl/adder_pipe_pkg.sv | 22 ++
 rtl/adder_pipe_arbiter_if.sv | 44 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/adder_pipe_arbiter.sv | 167 ++++++++++++++++
 tb/tb_adder_pipe_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared types and constants for the pipelined-adder arbiter.
// Ports: none (package).
package adder_pipe_pkg;

    localparam int unsigned ADD_DATA_WIDTH = 64;
    localparam int unsigned ADD_LATENCY    = 4;
    localparam int unsigned ADD_NUM_REQ    = 4;
    localparam int unsigned ADD_ID_W       = $clog2(ADD_NUM_REQ);

    // Tag travelling alongside each in-flight adder operation.
    typedef struct packed {
        logic                valid;
        logic [ADD_ID_W-1:0] id;
    } add_tag_t;

    // Response FIFO entry.
    typedef struct packed {
        logic [ADD_ID_W-1:0]       id;
        logic [ADD_DATA_WIDTH-1:0] data;
    } add_rsp_t;

endpackage

// File: rtl/adder_pipe_arbiter_if.sv
// Bus bundle for adder_pipe_arbiter: request side, adder side, response side
// and status. slave = arbiter view, master = environment view.
//   req_valid/req_ready/req_adda/req_addb : per-requester operand handshake
//   add_i_en/add_a/add_b                  : issue into the external adder
//   add_result/add_o_en                   : adder return
//   rsp_valid/rsp_ready/rsp_id/rsp_data   : response handshake
//   busy/err                              : status
interface adder_pipe_arbiter_if
    import adder_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ADD_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = ADD_NUM_REQ
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_adda;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_addb;
    logic                          add_i_en;
    logic [DATA_WIDTH-1:0]         add_a;
    logic [DATA_WIDTH-1:0]         add_b;
    logic [DATA_WIDTH-1:0]         add_result;
    logic                          add_o_en;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          busy;
    logic                          err;

    modport slave (
        input  req_valid, req_adda, req_addb, add_result, add_o_en, rsp_ready,
        output req_ready, add_i_en, add_a, add_b, rsp_valid, rsp_id, rsp_data,
               busy, err
    );

    modport master (
        output req_valid, req_adda, req_addb, add_result, add_o_en, rsp_ready,
        input  req_ready, add_i_en, add_a, add_b, rsp_valid, rsp_id, rsp_data,
               busy, err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past ptr_i.
//   req_i : request vector      ptr_i : last granted index
//   en_i  : allow any grant     gnt_o : one-hot grant   id_o : grant index
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    id_o
);

    logic              found;
    int unsigned       pos;
    logic [ID_W-1:0]   sel;

    // Scan ptr+1 .. ptr+NUM_REQ (wrapping) and take the first requester.
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        if (en_i) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                pos = 32'(ptr_i) + k;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                sel = ID_W'(pos);
                if (!found && req_i[sel]) begin
                    found      = 1'b1;
                    gnt_o[sel] = 1'b1;
                    id_o       = sel;
                end
            end
        end
    end

endmodule

// File: rtl/adder_pipe_arbiter.sv
// Shares one fixed-latency, non-stallable adder among NUM_REQ requesters.
// Issue is credit-limited so the response FIFO can always absorb every
// returning result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : adder_pipe_arbiter_if.slave (requests, adder, responses, status)
// Optional build macro ADDER_PIPE_ARB_CHECK_EN enables the sticky err checker;
// without it err is tied low.
module adder_pipe_arbiter
    import adder_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ADD_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = ADD_NUM_REQ,
    parameter int unsigned LATENCY    = ADD_LATENCY,
    parameter int unsigned RSP_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_pipe_arbiter_if.slave  bus
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    last_q;
    logic               issue;
    logic               arb_en;

    add_tag_t           tag_q [LATENCY];
    add_tag_t           tail;

    add_rsp_t           mem_q [RSP_DEPTH];
    add_rsp_t           rd_entry;
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]   used_q, used_d;
    logic               busy_q;
    logic               fifo_full, push_req, push, pop;

    // Credit: every issued op owns a FIFO slot until it is popped.
    assign arb_en = !rst && (used_q < CNT_W'(RSP_DEPTH));

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (last_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .id_o  (gnt_id)
    );

    assign issue         = |gnt;
    assign bus.req_ready = gnt;
    assign bus.add_i_en  = issue;

    // Operand mux for the granted requester.
    always_comb begin
        bus.add_a = '0;
        bus.add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                bus.add_a = bus.req_adda[i*DATA_WIDTH +: DATA_WIDTH];
                bus.add_b = bus.req_addb[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (issue) begin
            last_q <= gnt_id;
        end
    end

    // Tag pipe mirrors the adder so each result knows its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: issue, id: ADD_ID_W'(gnt_id)};
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tail      = tag_q[LATENCY-1];
    assign fifo_full = (fifo_cnt_q == CNT_W'(RSP_DEPTH));
    assign pop       = bus.rsp_valid && bus.rsp_ready;
    assign push_req  = tail.valid && bus.add_o_en;
    assign push      = push_req && (!fifo_full || pop);

    // A tagged op leaves the pipe every cycle its tail is valid; if it was
    // not pushed its credit is returned here.
    assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign used_d     = used_q + CNT_W'(issue) - CNT_W'(pop)
                      - CNT_W'(tail.valid && !push);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            fifo_cnt_q <= '0;
            used_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_q <= PTR_W'(wr_q + 1'b1);
            end
            if (pop) begin
                rd_q <= PTR_W'(rd_q + 1'b1);
            end
            fifo_cnt_q <= fifo_cnt_d;
            used_q     <= used_d;
            busy_q     <= (used_d != '0);
        end
    end

    // Storage needs no reset; outputs are gated by rsp_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= '{id: tail.id, data: ADD_DATA_WIDTH'(bus.add_result)};
        end
    end

    assign rd_entry      = mem_q[rd_q];
    assign bus.rsp_valid = (fifo_cnt_q != '0);
    assign bus.rsp_id    = bus.rsp_valid ? ID_W'(rd_entry.id) : '0;
    assign bus.rsp_data  = bus.rsp_valid ? DATA_WIDTH'(rd_entry.data) : '0;
    assign bus.busy      = busy_q;

`ifdef ADDER_PIPE_ARB_CHECK_EN
    localparam int unsigned HOLD_W = $clog2(LATENCY + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              err_q;
    logic              proto_err;

    // Tail/return disagreement or an overflow attempt.
    assign proto_err = (bus.add_o_en != tail.valid) ||
                       (push_req && fifo_full && !pop);

    // Checks are masked for LATENCY cycles after reset so an adder reset
    // on another domain can drain stale returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= HOLD_W'(LATENCY);
            err_q  <= 1'b0;
        end else begin
            if (hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end else if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Self-checking bench for adder_pipe_arbiter: directed phases with literal
// expectations plus a queue-based reference checked every cycle.
module tb_adder_pipe_arbiter;
    import adder_pipe_pkg::*;

    localparam int unsigned DW    = 64;
    localparam int unsigned NR    = 4;
    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 8;
`ifdef ADDER_PIPE_ARB_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_pipe_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    adder_pipe_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // External adder: fixed latency, not reset (separate domain).
    logic [LAT-1:0] ad_en = '0;
    logic [DW-1:0]  ad_sum [LAT];
    logic           inj = 1'b0;

    always @(posedge clk) begin
        ad_en     <= {ad_en[LAT-2:0], bus.add_i_en};
        ad_sum[0] <= bus.add_a + bus.add_b;
        for (int k = 1; k < LAT; k++) ad_sum[k] <= ad_sum[k-1];
    end

    assign bus.add_o_en   = ad_en[LAT-1] | inj;
    assign bus.add_result = ad_sum[LAT-1];

    // Reference model: ordered list of expected responses, each with the
    // first cycle it may appear; credit = issued but not yet popped.
    typedef struct {
        int          id;
        logic [63:0] sum;
        int          rdy;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          outstanding = 0;
    int          last_g = NR - 1;
    int          last_rst = 0;
    logic        err_m = 1'b0;
    bit          iss [4096];
    logic [NR-1:0] m_gnt;
    int          m_id;
    logic        m_rv;
    logic        m_tv;

    always @(negedge clk) begin
        m_gnt = '0;
        m_id  = 0;
        if (!rst && outstanding < int'(DEPTH)) begin
            for (int k = 1; k <= int'(NR); k++) begin
                if (m_gnt == '0 && bus.req_valid[(last_g + k) % NR]) begin
                    m_id        = (last_g + k) % NR;
                    m_gnt[m_id] = 1'b1;
                end
            end
        end
        m_rv = (q.size() > 0) && (q[0].rdy <= cyc);

        if (cyc > 0) begin
            chk("req_ready", 64'(bus.req_ready), 64'(m_gnt));
            chk("add_i_en", 64'(bus.add_i_en), 64'(m_gnt != '0));
            if (m_gnt != '0) begin
                chk("add_a", bus.add_a, bus.req_adda[m_id*DW +: DW]);
                chk("add_b", bus.add_b, bus.req_addb[m_id*DW +: DW]);
            end
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
            if (m_rv) begin
                chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
                chk("rsp_data", bus.rsp_data, q[0].sum);
            end
            chk("busy", 64'(bus.busy), 64'(outstanding != 0));
            chk("err", 64'(bus.err), 64'(err_m));
        end

        if (rst) begin
            q.delete();
            outstanding = 0;
            last_g      = NR - 1;
            err_m       = 1'b0;
            last_rst    = cyc;
        end else begin
            if (m_gnt != '0) begin
                q.push_back('{m_id,
                    bus.req_adda[m_id*DW +: DW] + bus.req_addb[m_id*DW +: DW],
                    cyc + LAT + 1});
                outstanding++;
                last_g   = m_id;
                iss[cyc] = 1'b1;
            end
            if (m_rv && bus.rsp_ready) begin
                void'(q.pop_front());
                outstanding--;
            end
`ifdef ADDER_PIPE_ARB_CHECK_EN
            if (cyc > last_rst + int'(LAT)) begin
                m_tv = (cyc >= int'(LAT)) && iss[cyc-LAT] && (cyc - int'(LAT) > last_rst);
                if (bus.add_o_en != m_tv) err_m = 1'b1;
            end
`endif
        end
        cyc++;
    end

    // Stimulus helpers.
    int   opn [NR];
    logic ops_en = 1'b1;

    task automatic drive_ops();
        for (int i = 0; i < int'(NR); i++) begin
            bus.req_adda[i*DW +: DW] = 64'h0123_4567_89AB_CDEF * 64'(i + 1)
                                     + 64'(opn[i]) * 64'h0000_0001_0000_0001;
            bus.req_addb[i*DW +: DW] = 64'hFFFF_FFFF_0000_0000 + 64'(opn[i] * 3 + i);
        end
    endtask

    task automatic run_cycle(input logic [NR-1:0] v, input logic rr, input logic ij,
                             output logic [NR-1:0] g, output logic rv);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = v;
        bus.rsp_ready = rr;
        inj           = ij;
        if (ops_en) drive_ops();
        @(negedge clk);
        g  = bus.req_ready;
        rv = bus.rsp_valid && bus.rsp_ready;
        for (int i = 0; i < int'(NR); i++) if (g[i] && v[i]) opn[i]++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst           = 1'b1;
            bus.req_valid = '0;
            bus.rsp_ready = 1'b0;
            inj           = 1'b0;
            @(negedge clk);
            if (i == n - 1) begin
                chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
                chk("rst_add_i_en", 64'(bus.add_i_en), 64'h0);
                chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
                chk("rst_rsp_id", 64'(bus.rsp_id), 64'h0);
                chk("rst_rsp_data", bus.rsp_data, 64'h0);
                chk("rst_busy", 64'(bus.busy), 64'h0);
                chk("rst_err", 64'(bus.err), 64'h0);
            end
        end
    endtask

    logic [NR-1:0] g;
    logic          rv;
    int            cnt;
    int            gcnt;
    int            gk;

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_adda  = '0;
        bus.req_addb  = '0;
        for (int i = 0; i < int'(NR); i++) opn[i] = 0;
        do_reset(3);

        // Fairness: all requesters valid, grants rotate from 0.
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            run_cycle(4'b1111, 1'b1, 1'b0, g, rv);
            chk("fair_gnt", 64'(g), 64'(4'b0001 << (k % 4)));
            cnt += int'(rv);
        end
        for (int k = 0; k < 10; k++) begin
            run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
            cnt += int'(rv);
        end
        chk("fair_rsp_count", 64'(cnt), 64'd16);

        // Single request from requester 2.
        do_reset(2);
        ops_en = 1'b0;
        bus.req_adda[2*DW +: DW] = 64'h0000_0000_FFFF_FFFF;
        bus.req_addb[2*DW +: DW] = 64'h1;
        run_cycle(4'b0100, 1'b1, 1'b0, g, rv);
        chk("single_gnt", 64'(g), 64'b0100);
        chk("single_add_a", bus.add_a, 64'h0000_0000_FFFF_FFFF);
        for (int k = 1; k < 5; k++) begin
            run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
            chk("single_early", 64'(bus.rsp_valid), 64'h0);
        end
        run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("single_rsp_id", 64'(bus.rsp_id), 64'd2);
        chk("single_rsp_data", bus.rsp_data, 64'h0000_0001_0000_0000);
        ops_en = 1'b1;

        // Backpressure: credit caps outstanding ops at the FIFO depth.
        cnt  = 0;
        gcnt = 0;
        for (int k = 0; k < 14; k++) begin
            run_cycle(4'b0001, 1'b0, 1'b0, g, rv);
            gcnt += int'(g[0]);
        end
        chk("bp_grants", 64'(gcnt), 64'd8);
        chk("bp_stalled", 64'(g), 64'h0);
        // One pop; the credit is usable only from the next cycle.
        run_cycle(4'b0001, 1'b1, 1'b0, g, rv);
        cnt += int'(rv);
        chk("bp_pop_cycle_gnt", 64'(g), 64'h0);
        // Full boundary: pop in the same cycle the in-flight result lands.
        gcnt = 0;
        gk   = -100;
        for (int k = 0; k < 10; k++) begin
            run_cycle(4'b0001, (k == gk + 4), 1'b0, g, rv);
            cnt += int'(rv);
            if (g[0]) begin
                gcnt++;
                if (gk < 0) gk = k;
            end
        end
        chk("bp_extra_grants", 64'(gcnt), 64'd2);
        for (int k = 0; k < 20; k++) begin
            run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
            cnt += int'(rv);
        end
        chk("bp_rsp_count", 64'(cnt), 64'd10);

        // Reset mid-flight: three grants, reset, nothing comes back.
        run_cycle(4'b0111, 1'b1, 1'b0, g, rv);
        chk("mid_gnt0", 64'(g), 64'b0010);
        run_cycle(4'b0111, 1'b1, 1'b0, g, rv);
        chk("mid_gnt1", 64'(g), 64'b0100);
        run_cycle(4'b0111, 1'b1, 1'b0, g, rv);
        chk("mid_gnt2", 64'(g), 64'b0001);
        run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
        do_reset(2);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
            cnt += int'(bus.rsp_valid);
        end
        chk("mid_no_rsp", 64'(cnt), 64'd0);
        chk("mid_busy", 64'(bus.busy), 64'h0);

        // Spurious adder return with an empty tag pipe.
        run_cycle(4'b0000, 1'b1, 1'b1, g, rv);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
            chk("inj_err", 64'(bus.err), 64'(EXP_ERR));
            cnt += int'(bus.rsp_valid);
        end
        chk("inj_no_rsp", 64'(cnt), 64'd0);
        do_reset(2);
        run_cycle(4'b0000, 1'b1, 1'b0, g, rv);
        chk("err_cleared", 64'(bus.err), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
